// File: rtl/gnss_pkg.sv
// Shared GPS C/A definitions: code length, LFSR width, FSM states, PRN-to-G2-tap lookup.
// Pure declarations; no logic of its own.
package gnss_pkg;

  localparam int LFSR_W = 10;
  localparam int CA_LEN = 1023;

  typedef enum logic [1:0] {IDLE, SLEW, RUN} ca_state_t;

  // Returns a one-hot-pair mask over g2[10:1] selecting the two phase-select taps.
  // Unknown PRNs map to an empty mask.
  function automatic logic [LFSR_W:1] prn_taps(input logic [5:0] prn);
    logic [7:0]        pair;
    logic [LFSR_W:1]   mask;
    case (prn)
      6'd1:  pair = 8'h26;  6'd2:  pair = 8'h37;  6'd3:  pair = 8'h48;  6'd4:  pair = 8'h59;
      6'd5:  pair = 8'h19;  6'd6:  pair = 8'h2A;  6'd7:  pair = 8'h18;  6'd8:  pair = 8'h29;
      6'd9:  pair = 8'h3A;  6'd10: pair = 8'h23;  6'd11: pair = 8'h34;  6'd12: pair = 8'h56;
      6'd13: pair = 8'h67;  6'd14: pair = 8'h78;  6'd15: pair = 8'h89;  6'd16: pair = 8'h9A;
      6'd17: pair = 8'h14;  6'd18: pair = 8'h25;  6'd19: pair = 8'h36;  6'd20: pair = 8'h47;
      6'd21: pair = 8'h58;  6'd22: pair = 8'h69;  6'd23: pair = 8'h13;  6'd24: pair = 8'h46;
      6'd25: pair = 8'h57;  6'd26: pair = 8'h68;  6'd27: pair = 8'h79;  6'd28: pair = 8'h8A;
      6'd29: pair = 8'h16;  6'd30: pair = 8'h27;  6'd31: pair = 8'h38;  6'd32: pair = 8'h49;
      default: pair = 8'h00;
    endcase
    mask = '0;
    if (pair != 8'h00) begin
      mask[pair[7:4]] = 1'b1;
      mask[pair[3:0]] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/ca_lfsr_pair.sv
// G1/G2 shift-register pair with all-ones load and advance enables; code bit is combinational
// from current register state (zero latency). Load takes priority over advance.
module ca_lfsr_pair
  import gnss_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [LFSR_W:1]   taps,
  output logic              code
);

  logic [LFSR_W:1] g1;
  logic [LFSR_W:1] g2;
  logic            g1_fb;
  logic            g2_fb;

  assign g1_fb = g1[3] ^ g1[10];
  assign g2_fb = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
  assign code  = g1[LFSR_W] ^ (^(g2 & taps));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g1 <= '1;
      g2 <= '1;
    end else if (load) begin
      g1 <= '1;
      g2 <= '1;
    end else if (adv) begin
      g1 <= {g1[LFSR_W-1:1], g1_fb};
      g2 <= {g2[LFSR_W-1:1], g2_fb};
    end
  end

endmodule

// File: rtl/ca_code_gen.sv
// GPS C/A chip generator: start loads PRN/phase, slews one chip per cycle to the phase, then streams.
// First chip phase+1 cycles after start; in RUN a chip is held until chip_ready, slewing ignores it.
module ca_code_gen #(
  parameter int PRN_MAX = 32,
  parameter int CA_LEN  = gnss_pkg::CA_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  prn,
  input  logic [9:0]  phase,
  input  logic        stop,
  input  logic        chip_ready,
  output logic        chip_valid,
  output logic        chip,
  output logic [9:0]  chip_idx,
  output logic        epoch,
  output logic        busy,
  output logic        err
);
  import gnss_pkg::LFSR_W, gnss_pkg::prn_taps, gnss_pkg::ca_state_t;
  import gnss_pkg::IDLE, gnss_pkg::SLEW, gnss_pkg::RUN;

  localparam logic [9:0] LAST_IDX = 10'(CA_LEN - 1);
  localparam logic [5:0] PRN_TOP  = 6'(PRN_MAX);

  ca_state_t        state_q, state_d;
  logic [9:0]       idx_q, idx_d, phase_q, phase_d, idx_nxt;
  logic [LFSR_W:1]  taps_q, taps_d;
  logic             err_q, err_d;
  logic             req_ok, load, adv, step, code;

  assign req_ok  = (prn != 6'd0) && (prn <= PRN_TOP) && (phase <= LAST_IDX);
  assign idx_nxt = (idx_q == LAST_IDX) ? 10'd0 : idx_q + 10'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    taps_d  = taps_q;
    err_d   = err_q;
    load    = 1'b0;
    adv     = 1'b0;
    step    = 1'b0;
    if (start) begin
      if (req_ok) begin
        load    = 1'b1;
        idx_d   = 10'd0;
        phase_d = phase;
        taps_d  = prn_taps(prn);
        err_d   = 1'b0;
        state_d = (phase == 10'd0) ? RUN : SLEW;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        SLEW: begin
          step = 1'b1;
          if (idx_nxt == phase_q) state_d = RUN;
        end
        RUN:     step = chip_ready;
        default: step = 1'b0;
      endcase
    end
    // Index 0 is defined as all-ones, so wrapping reloads rather than trusting the period.
    if (step) begin
      idx_d = idx_nxt;
      if (idx_q == LAST_IDX) load = 1'b1;
      else                   adv  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      phase_q <= '0;
      taps_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      taps_q  <= taps_d;
      err_q   <= err_d;
    end
  end

  ca_lfsr_pair u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .adv  (adv),
    .taps (taps_q),
    .code (code)
  );

  assign chip_valid = (state_q == RUN);
  assign busy       = (state_q == SLEW);
  assign chip       = chip_valid & code;
  assign chip_idx   = idx_q;
  assign epoch      = chip_valid && (idx_q == 10'd0);
  assign err        = err_q;

endmodule

// File: tb/tb_ca_code_gen.sv
// Directed bench for ca_code_gen: known code heads, slew latency, rotation, backpressure, wrap, errors, reset.
module tb_ca_code_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       chip_ready = 1'b1;
  logic [5:0] prn = '0;
  logic [9:0] phase = '0;
  logic       chip_valid, chip, epoch, busy, err;
  logic [9:0] chip_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic ref1  [0:1022];
  logic ref31 [0:1022];
  logic s123  [0:1022];

  logic [5:0] bad_prn [3] = '{6'd0, 6'd33, 6'd1};
  logic [9:0] bad_ph  [3] = '{10'd0, 10'd0, 10'd1023};

  always #5 clk = ~clk;

  ca_code_gen #(.PRN_MAX(32), .CA_LEN(1023)) dut (
    .clk(clk), .rst(rst), .start(start), .prn(prn), .phase(phase), .stop(stop),
    .chip_ready(chip_ready), .chip_valid(chip_valid), .chip(chip), .chip_idx(chip_idx),
    .epoch(epoch), .busy(busy), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] p, input logic [9:0] ph);
    prn = p; phase = ph; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // cycles counts from the start cycle; bounded so a dead DUT cannot hang the run
  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (!chip_valid && cycles < 2000) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    n_checks++; if (chip_valid !== 1'b0) begin n_fail++; $display("FAIL reset_chip_valid: got %b want 0", chip_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if ({chip, epoch, err} !== 3'b000) begin n_fail++; $display("FAIL reset_chip_epoch_err: got %b want 000", {chip, epoch, err}); end
    n_checks++; if (chip_idx !== 10'd0) begin n_fail++; $display("FAIL reset_chip_idx: got %0d want 0", chip_idx); end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) step();
    n_checks++; if (chip_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_release: valid %b busy %b want 0 0", chip_valid, busy); end
  endtask

  task automatic test_prn1_phase0();
    logic [9:0] head;
    int idx_err;
    chip_ready = 1'b1;
    do_start(6'd1, 10'd0);
    n_checks++; if (chip_valid !== 1'b1) begin n_fail++; $display("FAIL prn1_first_valid: got %b want 1", chip_valid); end
    n_checks++; if (epoch !== 1'b1) begin n_fail++; $display("FAIL prn1_first_epoch: got %b want 1", epoch); end
    idx_err = 0;
    for (int i = 0; i < 1023; i++) begin
      if (i > 0) step();
      ref1[i] = chip;
      if (chip_idx !== 10'(i) || chip_valid !== 1'b1) idx_err++;
      if (i == 1) begin
        n_checks++; if (epoch !== 1'b0) begin n_fail++; $display("FAIL prn1_epoch_idx1: got %b want 0", epoch); end
      end
    end
    head = '0;
    for (int i = 0; i < 10; i++) head[9-i] = ref1[i];
    n_checks++; if (head !== 10'b1100100000) begin n_fail++; $display("FAIL prn1_head: got %b want 1100100000", head); end
    n_checks++; if (idx_err != 0) begin n_fail++; $display("FAIL prn1_idx_sequence: got %0d bad cycles want 0", idx_err); end
    step();
    n_checks++; if (epoch !== 1'b1 || chip_idx !== 10'd0) begin n_fail++; $display("FAIL prn1_epoch_1023: epoch %b idx %0d want 1 0", epoch, chip_idx); end
    n_checks++; if (chip !== 1'b1) begin n_fail++; $display("FAIL prn1_wrap_chip: got %b want 1", chip); end
  endtask

  task automatic test_prn31_rotation();
    logic [9:0] head;
    int c, mism, off;
    do_start(6'd31, 10'd0);
    for (int i = 0; i < 1023; i++) begin
      if (i > 0) step();
      ref31[i] = chip;
    end
    head = '0;
    for (int i = 0; i < 10; i++) head[9-i] = ref31[i];
    n_checks++; if (head !== 10'b1110010101) begin n_fail++; $display("FAIL prn31_head: got %b want 1110010101", head); end
    do_start(6'd31, 10'd123);
    n_checks++; if (busy !== 1'b1 || chip_valid !== 1'b0) begin n_fail++; $display("FAIL prn31_slew_flags: busy %b valid %b want 1 0", busy, chip_valid); end
    wait_valid(c);
    n_checks++; if (c != 124) begin n_fail++; $display("FAIL prn31_slew_latency: got %0d want 124", c); end
    n_checks++; if (chip_idx !== 10'd123 || busy !== 1'b0) begin n_fail++; $display("FAIL prn31_slew_idx: idx %0d busy %b want 123 0", chip_idx, busy); end
    for (int i = 0; i < 1023; i++) begin
      if (i > 0) step();
      s123[i] = chip;
    end
    mism = 0; off = 0;
    for (int i = 0; i < 1023; i++) begin
      if (s123[i] !== ref31[(123 + i) % 1023]) mism++;
      if (s123[i] !== ref31[(124 + i) % 1023]) off++;
    end
    n_checks++; if (mism != 0) begin n_fail++; $display("FAIL prn31_rotation: got %0d mismatches want 0", mism); end
    n_checks++; if (off != 480 && off != 512 && off != 544) begin n_fail++; $display("FAIL prn31_offset1: got %0d mismatches want 480/512/544", off); end
  endtask

  task automatic test_backpressure();
    logic held;
    int bad;
    chip_ready = 1'b1;
    do_start(6'd1, 10'd0);
    repeat (10) step();
    n_checks++; if (chip_idx !== 10'd10) begin n_fail++; $display("FAIL bp_reach10: got %0d want 10", chip_idx); end
    chip_ready = 1'b0;
    held = chip;
    n_checks++; if (held !== ref1[10]) begin n_fail++; $display("FAIL bp_chip10: got %b want %b", held, ref1[10]); end
    bad = 0;
    repeat (5) begin
      step();
      if (chip_idx !== 10'd10 || chip !== held || chip_valid !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    chip_ready = 1'b1;
    step();
    n_checks++; if (chip_idx !== 10'd11) begin n_fail++; $display("FAIL bp_next_idx: got %0d want 11", chip_idx); end
    n_checks++; if (chip !== ref1[11]) begin n_fail++; $display("FAIL bp_chip11: got %b want %b", chip, ref1[11]); end
  endtask

  task automatic test_wrap();
    int c;
    logic [9:0] exp_idx [4] = '{10'd1020, 10'd1021, 10'd1022, 10'd0};
    do_start(6'd1, 10'd1020);
    wait_valid(c);
    n_checks++; if (c != 1021) begin n_fail++; $display("FAIL wrap_latency: got %0d want 1021", c); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      n_checks++; if (chip_idx !== exp_idx[k]) begin n_fail++; $display("FAIL wrap_idx%0d: got %0d want %0d", k, chip_idx, exp_idx[k]); end
      n_checks++; if (epoch !== (k == 3)) begin n_fail++; $display("FAIL wrap_epoch%0d: got %b want %b", k, epoch, (k == 3)); end
      n_checks++; if (chip !== ((k == 3) ? 1'b1 : ref1[1020 + k])) begin n_fail++; $display("FAIL wrap_chip%0d: got %b want %b", k, chip, ((k == 3) ? 1'b1 : ref1[1020 + k])); end
    end
  endtask

  task automatic test_invalid();
    for (int k = 0; k < 3; k++) begin
      do_start(bad_prn[k], bad_ph[k]);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL invalid%0d_err: got %b want 1", k, err); end
      n_checks++; if (chip_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL invalid%0d_idle: valid %b busy %b want 0 0", k, chip_valid, busy); end
      repeat (2) step();
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL invalid%0d_sticky: got %b want 1", k, err); end
    end
    do_start(6'd1, 10'd0);
    n_checks++; if (err !== 1'b0 || chip_valid !== 1'b1) begin n_fail++; $display("FAIL invalid_clear: err %b valid %b want 0 1", err, chip_valid); end
  endtask

  task automatic test_stop();
    stop = 1'b1; step(); stop = 1'b0;
    n_checks++; if (chip_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_run: valid %b busy %b want 0 0", chip_valid, busy); end
    prn = 6'd1; phase = 10'd0; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    n_checks++; if (chip_valid !== 1'b1 || chip_idx !== 10'd0) begin n_fail++; $display("FAIL start_stop_both: valid %b idx %0d want 1 0", chip_valid, chip_idx); end
    do_start(6'd1, 10'd50);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    n_checks++; if (busy !== 1'b0 || chip_valid !== 1'b0) begin n_fail++; $display("FAIL stop_slew: busy %b valid %b want 0 0", busy, chip_valid); end
  endtask

  task automatic test_reset_mid_slew();
    int bad;
    do_start(6'd1, 10'd500);
    repeat (20) step();
    n_checks++; if (busy !== 1'b1 || chip_idx !== 10'd20) begin n_fail++; $display("FAIL slew_progress: busy %b idx %0d want 1 20", busy, chip_idx); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || chip_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: busy %b valid %b err %b want 0 0 0", busy, chip_valid, err); end
    n_checks++; if (chip_idx !== 10'd0) begin n_fail++; $display("FAIL async_reset_idx: got %0d want 0", chip_idx); end
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 0;
    repeat (600) begin
      step();
      if (chip_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL reset_discards_request: got %0d active cycles want 0", bad); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_prn1_phase0();
    test_prn31_rotation();
    test_backpressure();
    test_wrap();
    test_invalid();
    test_stop();
    test_reset_mid_slew();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
